// File: rtl/decode_stream.sv
// Registered, valid/ready index decoder (one-hot or thermometer) with a 2-entry
// skid buffer: full throughput, registered in_ready_o, out-of-range flagging.
module decode_stream #(
  parameter  int Width = 8,
  localparam int AW    = $clog2(Width)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [AW-1:0]    in_a_i,
  input  logic             in_mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_z_o,
  output logic             out_err_o
);

  typedef struct packed {
    logic [Width-1:0] z;
    logic             err;
  } beat_t;

  beat_t main_q, main_d, skid_q, skid_d, in_beat;
  logic  main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic  accept, transfer;

  // Indices >= Width only exist when Width is not a power of two.
  function automatic beat_t decode(input logic [AW-1:0] a, input logic mode);
    beat_t b;
    b.err = (int'(a) >= Width);
    b.z   = '0;
    for (int i = 0; i < Width; i++) begin
      b.z[i] = !b.err && (mode ? (i <= int'(a)) : (i == int'(a)));
    end
    return b;
  endfunction

  assign in_beat  = decode(in_a_i, in_mode_i);
  assign accept   = in_valid_i & ~skid_valid_q;
  assign transfer = main_valid_q & out_ready_i;

  always_comb begin
    // NOTE: every _d gets a default before any branch, so no path leaves one
    // unassigned and no latch is inferred.
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (transfer && skid_valid_q) begin
      // in_ready_o is low while skid is full, so no accept can collide here.
      main_d       = skid_q;
      skid_valid_d = 1'b0;
    end else if (accept && (!main_valid_q || transfer)) begin
      main_d       = in_beat;
      main_valid_d = 1'b1;
    end else if (accept) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end else if (transfer) begin
      main_valid_d = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments; data payloads are reset too so
  // out_z_o/out_err_o read zero straight out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready_o  = ~skid_valid_q;
  assign out_valid_o = main_valid_q;
  assign out_z_o     = main_q.z;
  assign out_err_o   = main_q.err;

endmodule

// File: tb/tb_decode_stream.sv
// Self-checking bench for decode_stream: Width=8 streaming against a queue
// model, plus Width=5 and Width=2 instances for range and boundary cases.
module tb_decode_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       v8 = 0, or8 = 0, m8 = 0, r8, ov8, e8;
  logic [2:0] a8 = '0;
  logic [7:0] z8;
  logic       v5 = 0, or5 = 1, m5 = 0, r5, ov5, e5;
  logic [2:0] a5 = '0;
  logic [4:0] z5;
  logic       v2 = 0, or2 = 1, m2 = 0, r2, ov2, e2;
  logic [0:0] a2 = '0;
  logic [1:0] z2;

  decode_stream #(.Width(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v8), .in_ready_o(r8), .in_a_i(a8),
    .in_mode_i(m8), .out_valid_o(ov8), .out_ready_i(or8), .out_z_o(z8), .out_err_o(e8));
  decode_stream #(.Width(5)) dut5 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v5), .in_ready_o(r5), .in_a_i(a5),
    .in_mode_i(m5), .out_valid_o(ov5), .out_ready_i(or5), .out_z_o(z5), .out_err_o(e5));
  decode_stream #(.Width(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v2), .in_ready_o(r2), .in_a_i(a2),
    .in_mode_i(m2), .out_valid_o(ov2), .out_ready_i(or2), .out_z_o(z2), .out_err_o(e2));

  typedef struct {
    logic [7:0] z;
    logic       e;
  } exp_t;

  int         total = 0;
  int         bad = 0;
  int         n_acc = 0;
  exp_t       q[$];
  bit         prev_stall = 0;
  logic [7:0] prev_z;
  logic       prev_e;
  bit         popped;
  logic [7:0] last_z;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: one-hot is 1<<A, thermometer is the low A+1 bits set.
  function automatic exp_t mdl(input int w, input int a, input bit m);
    exp_t r;
    if (a >= w) begin
      r.z = 8'h00;
      r.e = 1'b1;
    end else begin
      r.e = 1'b0;
      r.z = m ? 8'((1 << (a + 1)) - 1) : 8'(1 << a);
    end
    return r;
  endfunction

  // One Width=8 cycle: sample at negedge, score handshakes, advance past posedge.
  task automatic cyc8();
    exp_t ex;
    @(negedge clk);
    popped = 0;
    if (prev_stall) begin
      check("stall_valid", 32'(ov8), 1);
      check("stall_z", 32'(z8), 32'(prev_z));
      check("stall_err", 32'(e8), 32'(prev_e));
    end
    if (ov8 && or8) begin
      check("beat_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        ex = q.pop_front();
        check("out_z", 32'(z8), 32'(ex.z));
        check("out_err", 32'(e8), 32'(ex.e));
      end
      popped = 1;
      last_z = z8;
    end
    if (v8 && r8) begin
      q.push_back(mdl(8, int'(a8), m8));
      n_acc++;
    end
    prev_stall = ov8 && !or8;
    prev_z = z8;
    prev_e = e8;
    @(posedge clk);
    #1;
  endtask

  task automatic beat5(input logic [2:0] a, input bit m, input logic [4:0] ez,
                       input bit ee, input string tag);
    exp_t ex;
    ex = mdl(5, int'(a), m);
    v5 = 1; a5 = a; m5 = m;
    @(posedge clk); #1;
    v5 = 0;
    check({tag, "_valid"}, 32'(ov5), 1);
    check({tag, "_z"}, 32'(z5), 32'(ez));
    check({tag, "_err"}, 32'(e5), 32'(ee));
    check({tag, "_model"}, 32'(z5), 32'(ex.z));
    @(posedge clk); #1;
    check({tag, "_drained"}, 32'(ov5), 0);
  endtask

  task automatic beat2(input logic a, input bit m, input logic [1:0] ez, input string tag);
    v2 = 1; a2 = a; m2 = m;
    @(posedge clk); #1;
    v2 = 0;
    check({tag, "_z"}, 32'(z2), 32'(ez));
    check({tag, "_err"}, 32'(e2), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_valid", 32'(ov8), 0);
    check("rst_ready", 32'(r8), 1);
    check("rst_z", 32'(z8), 0);
    check("rst_err", 32'(e8), 0);
    check("rst_valid5", 32'(ov5), 0);
    check("rst_valid2", 32'(ov2), 0);
    #10 rst_n = 1;
    @(posedge clk); #1;

    // T1: one-hot A=5, latency one cycle
    or8 = 1; v8 = 1; a8 = 3'd5; m8 = 0;
    cyc8();
    v8 = 0;
    cyc8();
    check("t1_popped", 32'(popped), 1);
    check("t1_z", 32'(last_z), 32'h20);

    // T2: thermometer 0/3/7 back-to-back with no bubbles
    m8 = 1; v8 = 1; a8 = 3'd0;
    cyc8();
    a8 = 3'd3;
    cyc8();
    check("t2_p0", 32'(popped), 1);
    check("t2_z0", 32'(last_z), 32'h01);
    a8 = 3'd7;
    cyc8();
    check("t2_p1", 32'(popped), 1);
    check("t2_z1", 32'(last_z), 32'h0F);
    v8 = 0;
    cyc8();
    check("t2_p2", 32'(popped), 1);
    check("t2_z2", 32'(last_z), 32'hFF);

    // T3 / Width=5 boundaries and Width=2
    beat5(3'd6, 1'b0, 5'b00000, 1'b1, "t3_a6_oh");
    beat5(3'd6, 1'b1, 5'b00000, 1'b1, "t3_a6_th");
    beat5(3'd4, 1'b1, 5'b11111, 1'b0, "t3_a4_th");
    beat5(3'd5, 1'b0, 5'b00000, 1'b1, "t3_a5_oh");
    beat5(3'd7, 1'b1, 5'b00000, 1'b1, "t3_a7_th");
    beat5(3'd2, 1'b0, 5'b00100, 1'b0, "t3_a2_oh");
    beat5(3'd2, 1'b1, 5'b00111, 1'b0, "t3_a2_th");
    beat2(1'b0, 1'b0, 2'b01, "w2_a0_oh");
    beat2(1'b1, 1'b0, 2'b10, "w2_a1_oh");
    beat2(1'b0, 1'b1, 2'b01, "w2_a0_th");
    beat2(1'b1, 1'b1, 2'b11, "w2_a1_th");

    // T4: stall with 3 beats offered, then release
    or8 = 0; m8 = 0; v8 = 1; a8 = 3'd1;
    cyc8();
    a8 = 3'd2;
    cyc8();
    a8 = 3'd3;
    for (int i = 0; i < 3; i++) begin
      cyc8();
      check("t4_in_ready", 32'(r8), 0);
      check("t4_out_valid", 32'(ov8), 1);
    end
    or8 = 1;
    cyc8();
    check("t4_p1", 32'(popped), 1);
    check("t4_z1", 32'(last_z), 32'h02);
    cyc8();
    check("t4_p2", 32'(popped), 1);
    check("t4_z2", 32'(last_z), 32'h04);
    v8 = 0;
    cyc8();
    check("t4_p3", 32'(popped), 1);
    check("t4_z3", 32'(last_z), 32'h08);
    cyc8();
    check("t4_empty", 32'(q.size()), 0);

    // T5: random valid/ready against the model
    n_acc = 0;
    for (int c = 0; c < 60000 && n_acc < 10000; c++) begin
      v8 = ($urandom_range(0, 3) != 0);
      a8 = 3'($urandom);
      m8 = 1'($urandom);
      or8 = ($urandom_range(0, 3) != 0);
      cyc8();
    end
    check("t5_count", 32'(n_acc >= 10000), 1);
    v8 = 0; or8 = 1;
    for (int c = 0; c < 8; c++) cyc8();
    check("t5_drained", 32'(q.size()), 0);
    check("t5_idle", 32'(ov8), 0);

    // T6: async reset with both entries full
    or8 = 0; v8 = 1; m8 = 0; a8 = 3'd4;
    cyc8();
    a8 = 3'd6;
    cyc8();
    v8 = 0;
    cyc8();
    check("t6_full_valid", 32'(ov8), 1);
    check("t6_full_ready", 32'(r8), 0);
    #2 rst_n = 0;
    #1;
    check("t6_rst_valid", 32'(ov8), 0);
    check("t6_rst_ready", 32'(r8), 1);
    check("t6_rst_z", 32'(z8), 0);
    q.delete();
    prev_stall = 0;
    #3 rst_n = 1;
    @(posedge clk); #1;
    v8 = 1; a8 = 3'd7; m8 = 1; or8 = 1;
    cyc8();
    v8 = 0;
    cyc8();
    check("t6_p", 32'(popped), 1);
    check("t6_z", 32'(last_z), 32'hFF);
    check("t6_empty", 32'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
